// File: rtl/sm4_pkg.sv
// sm4_pkg: shared constants and helpers for the SM4 round-key store.
//   ROUND_NUM/WORD_WIDTH/ADDR_WIDTH/PIPE_DEPTH - default geometry
//   wr_state_e - writer FSM state encoding
//   rev_idx    - decrypt-order round index (n-1-idx)
package sm4_pkg;

  localparam int ROUND_NUM  = 32;
  localparam int WORD_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int PIPE_DEPTH = 4;

  typedef enum logic {WR_IDLE, WR_FILL} wr_state_e;

  function automatic int unsigned rev_idx(input int unsigned idx, input int unsigned n);
    return n - 1 - idx;
  endfunction

endpackage

// File: rtl/round_key_rd_port.sv
// round_key_rd_port: one registered read port of the round-key bank.
// Optional feature macro: ROUND_KEY_PARITY_EN (adds parity_bad output).
// Ports:
//   clk, rst_n      clock, async active-low reset
//   stall           hold rd_data/rd_vld
//   rd_bank/round   requested bank and round index
//   rd_dec          decrypt order (index reversed)
//   bank_ready      per-bank complete flags
//   mem             full key storage (combinational read)
//   rd_data/rd_vld  registered key word and its valid
//   parity_bad      combinational: this cycle's valid read has bad parity
module round_key_rd_port #(
  parameter int NUM_BANKS  = 2,
  parameter int ROUND_NUM  = 32,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BANK_W     = 1,
  parameter int MEM_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic [BANK_W-1:0]     rd_bank,
  input  logic [ADDR_WIDTH-1:0] rd_round,
  input  logic                  rd_dec,
  input  logic [NUM_BANKS-1:0]  bank_ready,
  input  logic [MEM_W-1:0]      mem [NUM_BANKS][ROUND_NUM],
`ifdef ROUND_KEY_PARITY_EN
  output logic                  parity_bad,
`endif
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_vld
);
  import sm4_pkg::rev_idx;

  localparam int RI_W = (ROUND_NUM > 1) ? $clog2(ROUND_NUM) : 1;

  logic                  in_range;
  logic [BANK_W-1:0]     bi;
  logic [RI_W-1:0]       ri;
  logic [MEM_W-1:0]      word;
  logic                  vld_n;
  logic [WORD_WIDTH-1:0] data_n;
  logic [WORD_WIDTH-1:0] rd_data_d, rd_data_q;
  logic                  rd_vld_d, rd_vld_q;

  always_comb begin
    in_range = (32'(rd_round) < ROUND_NUM) && (32'(rd_bank) < NUM_BANKS);
    bi       = '0;
    ri       = '0;
    // Out-of-range requests index entry 0 so the array is never overrun;
    // the result is discarded because vld_n is 0.
    if (in_range) begin
      bi = rd_bank;
      ri = rd_dec ? RI_W'(rev_idx(32'(rd_round), ROUND_NUM)) : RI_W'(rd_round);
    end
    word      = mem[bi][ri];
    vld_n     = in_range && bank_ready[bi];
    data_n    = vld_n ? word[WORD_WIDTH-1:0] : '0;
    rd_data_d = stall ? rd_data_q : data_n;
    rd_vld_d  = stall ? rd_vld_q  : vld_n;
  end

`ifdef ROUND_KEY_PARITY_EN
  // Stored words carry even parity, so a good word XORs to 0.
  assign parity_bad = !stall && vld_n && (^word);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_vld  = rd_vld_q;

endmodule

// File: rtl/round_key_bank.sv
// round_key_bank: multi-bank SM4 round-key store with one write channel
// (start/valid/ready fill) and PIPE_DEPTH independent registered read ports.
// Optional feature macro: ROUND_KEY_PARITY_EN (per-word even parity and the
// sticky parity_err output).
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   wr_start/wr_bank             begin filling a bank (ignored if locked)
//   wr_valid/wr_data/wr_ready    round-key words in round order
//   fill_done                    pulse after the last word of a fill
//   bank_ready                   per-bank complete flag
//   bank_lock                    per-bank in-use flag from the pipeline
//   stall                        hold all read outputs
//   rd_bank/rd_round/rd_dec      packed per-port read requests
//   rd_data/rd_vld               packed per-port registered results
//   parity_err                   sticky parity error (feature only)
module round_key_bank #(
  parameter int NUM_BANKS  = 2,
  parameter int ROUND_NUM  = sm4_pkg::ROUND_NUM,
  parameter int PIPE_DEPTH = sm4_pkg::PIPE_DEPTH,
  parameter int WORD_WIDTH = sm4_pkg::WORD_WIDTH,
  parameter int ADDR_WIDTH = sm4_pkg::ADDR_WIDTH,
  parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_start,
  input  logic [BANK_W-1:0]                wr_bank,
  input  logic                             wr_valid,
  input  logic [WORD_WIDTH-1:0]            wr_data,
  output logic                             wr_ready,
  output logic                             fill_done,
  output logic [NUM_BANKS-1:0]             bank_ready,
  input  logic [NUM_BANKS-1:0]             bank_lock,
  input  logic                             stall,
  input  logic [BANK_W*PIPE_DEPTH-1:0]     rd_bank,
  input  logic [ADDR_WIDTH*PIPE_DEPTH-1:0] rd_round,
  input  logic [PIPE_DEPTH-1:0]            rd_dec,
`ifdef ROUND_KEY_PARITY_EN
  output logic                             parity_err,
`endif
  output logic [WORD_WIDTH*PIPE_DEPTH-1:0] rd_data,
  output logic [PIPE_DEPTH-1:0]            rd_vld
);
  import sm4_pkg::wr_state_e;
  import sm4_pkg::WR_IDLE;
  import sm4_pkg::WR_FILL;

`ifdef ROUND_KEY_PARITY_EN
  localparam int MEM_W = WORD_WIDTH + 1;
`else
  localparam int MEM_W = WORD_WIDTH;
`endif
  localparam int RI_W = (ROUND_NUM > 1) ? $clog2(ROUND_NUM) : 1;

  wr_state_e             state_d, state_q;
  logic [ADDR_WIDTH-1:0] wcnt_d, wcnt_q;
  logic [BANK_W-1:0]     bank_d, bank_q;
  logic [NUM_BANKS-1:0]  bank_ready_d, bank_ready_q;
  logic                  fill_done_d, fill_done_q;
  logic                  wr_ready_d, wr_ready_q;
  logic                  start_ok;
  logic                  mem_we;
  logic [MEM_W-1:0]      wword;
  logic [MEM_W-1:0]      mem_q [NUM_BANKS][ROUND_NUM];

  always_comb begin
    start_ok     = wr_start && (32'(wr_bank) < NUM_BANKS) && !bank_lock[wr_bank];
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    bank_d       = bank_q;
    bank_ready_d = bank_ready_q;
    fill_done_d  = 1'b0;
    mem_we       = 1'b0;
    // A new start takes priority over data: it aborts any fill in progress
    // and drops the word presented in the same cycle.
    if (start_ok) begin
      bank_d                = wr_bank;
      bank_ready_d[wr_bank] = 1'b0;
      wcnt_d                = '0;
      state_d               = WR_FILL;
    end else if (state_q == WR_FILL && wr_valid) begin
      mem_we = 1'b1;
      if (wcnt_q == ADDR_WIDTH'(ROUND_NUM - 1)) begin
        bank_ready_d[bank_q] = 1'b1;
        fill_done_d          = 1'b1;
        wcnt_d               = '0;
        state_d              = WR_IDLE;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
    wr_ready_d = (state_d == WR_FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WR_IDLE;
      wcnt_q       <= '0;
      bank_q       <= '0;
      bank_ready_q <= '0;
      fill_done_q  <= 1'b0;
      wr_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      bank_q       <= bank_d;
      bank_ready_q <= bank_ready_d;
      fill_done_q  <= fill_done_d;
      wr_ready_q   <= wr_ready_d;
    end
  end

`ifdef ROUND_KEY_PARITY_EN
  assign wword = {^wr_data, wr_data};
`else
  assign wword = wr_data;
`endif

  // Key storage is deliberately not reset; bank_ready gates every read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[bank_q][RI_W'(wcnt_q)] <= wword;
  end

  assign wr_ready   = wr_ready_q;
  assign fill_done  = fill_done_q;
  assign bank_ready = bank_ready_q;

`ifdef ROUND_KEY_PARITY_EN
  logic [PIPE_DEPTH-1:0] port_bad;
  logic                  parity_err_d, parity_err_q;

  assign parity_err_d = parity_err_q | (|port_bad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`endif

  for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_port
    round_key_rd_port #(
      .NUM_BANKS (NUM_BANKS),
      .ROUND_NUM (ROUND_NUM),
      .WORD_WIDTH(WORD_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .BANK_W    (BANK_W),
      .MEM_W     (MEM_W)
    ) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall),
      .rd_bank   (rd_bank[BANK_W*i +: BANK_W]),
      .rd_round  (rd_round[ADDR_WIDTH*i +: ADDR_WIDTH]),
      .rd_dec    (rd_dec[i]),
      .bank_ready(bank_ready_q),
      .mem       (mem_q),
`ifdef ROUND_KEY_PARITY_EN
      .parity_bad(port_bad[i]),
`endif
      .rd_data   (rd_data[WORD_WIDTH*i +: WORD_WIDTH]),
      .rd_vld    (rd_vld[i])
    );
  end

endmodule

// File: tb/tb_round_key_bank.sv
module tb_round_key_bank;
  localparam int NB = 2;
  localparam int RN = 32;
  localparam int PD = 4;
  localparam int WW = 32;
  localparam int AW = 6;
  localparam int BW = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_start;
  logic [BW-1:0]     wr_bank;
  logic              wr_valid;
  logic [WW-1:0]     wr_data;
  logic              wr_ready;
  logic              fill_done;
  logic [NB-1:0]     bank_ready;
  logic [NB-1:0]     bank_lock;
  logic              stall;
  logic [BW*PD-1:0]  rd_bank;
  logic [AW*PD-1:0]  rd_round;
  logic [PD-1:0]     rd_dec;
  logic [WW*PD-1:0]  rd_data;
  logic [PD-1:0]     rd_vld;
`ifdef ROUND_KEY_PARITY_EN
  logic              parity_err;
`endif

  round_key_bank #(
    .NUM_BANKS(NB), .ROUND_NUM(RN), .PIPE_DEPTH(PD),
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .BANK_W(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_start(wr_start), .wr_bank(wr_bank), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .fill_done(fill_done),
    .bank_ready(bank_ready), .bank_lock(bank_lock), .stall(stall),
    .rd_bank(rd_bank), .rd_round(rd_round), .rd_dec(rd_dec),
`ifdef ROUND_KEY_PARITY_EN
    .parity_err(parity_err),
`endif
    .rd_data(rd_data), .rd_vld(rd_vld)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [BW-1:0] b, input logic [AW-1:0] r,
                          input logic d);
    rd_bank[BW*p +: BW]  = b;
    rd_round[AW*p +: AW] = r;
    rd_dec[p]            = d;
  endtask

  function automatic logic [WW-1:0] dat(input int p);
    return rd_data[WW*p +: WW];
  endfunction

  task automatic start(input logic [BW-1:0] b);
    wr_start = 1'b1;
    wr_bank  = b;
    tick();
    wr_start = 1'b0;
  endtask

  task automatic write_words(input logic [WW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + WW'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_start = 1'b0; wr_bank = '0; wr_valid = 1'b0; wr_data = '0;
    bank_lock = '0; stall = 1'b0; rd_bank = '0; rd_round = '0; rd_dec = '0;
    tick(); tick();
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_bank_ready", bank_ready, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_data", rd_data[63:0], 0);
    rst_n = 1'b1;
    tick();

    // Fill bank0 with 0x1000+i
    start(0);
    chk("fill0_wr_ready", wr_ready, 1);
    chk("fill0_bank_ready_clr", bank_ready, 2'b00);
    write_words(32'h1000, 31);
    chk("fill0_not_done_yet", fill_done, 0);
    write_words(32'h101F, 1);
    chk("fill0_done", fill_done, 1);
    chk("fill0_bank_ready", bank_ready, 2'b01);
    chk("fill0_wr_ready_idle", wr_ready, 0);
    tick();
    chk("fill0_done_pulse", fill_done, 0);

    set_port(0, 0, 5, 0);
    tick();
    chk("p0_enc_r5", {rd_vld[0], dat(0)}, {1'b1, 32'h1005});
    set_port(0, 0, 5, 1);
    tick();
    chk("p0_dec_r5", {rd_vld[0], dat(0)}, {1'b1, 32'h101A});

    // Fill bank1 while port1 reads bank0 and port2 reads bank1
    set_port(1, 0, 31, 0);
    set_port(2, 1, 0, 0);
    start(1);
    for (int i = 0; i < RN; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'h2000 + WW'(i);
      tick();
      chk("p1_bank0_during_fill", {rd_vld[1], dat(1)}, {1'b1, 32'h101F});
      chk("p2_bank1_during_fill", {rd_vld[2], dat(2)}, {1'b0, 32'h0});
    end
    wr_valid = 1'b0;
    chk("fill1_done", fill_done, 1);
    tick();
    chk("p2_bank1_after_fill", {rd_vld[2], dat(2)}, {1'b1, 32'h2000});
    chk("both_ready", bank_ready, 2'b11);

    // Locked start is ignored
    bank_lock = 2'b01;
    wr_start = 1'b1; wr_bank = 0;
    tick();
    wr_start = 1'b0;
    chk("lock_wr_ready", wr_ready, 0);
    chk("lock_bank_ready", bank_ready, 2'b11);
    tick();
    chk("lock_wr_ready_2", wr_ready, 0);
    bank_lock = 2'b00;
    start(0);
    chk("unlock_bank_ready", bank_ready, 2'b10);
    chk("unlock_wr_ready", wr_ready, 1);
    tick();
    chk("p0_read_filling_bank", {rd_vld[0], dat(0)}, {1'b0, 32'h0});

    // Abort the bank0 fill after 10 words by starting bank1
    write_words(32'h3000, 10);
    wr_start = 1'b1; wr_bank = 1; wr_valid = 1'b1; wr_data = 32'hDEAD;
    tick();
    wr_start = 1'b0; wr_valid = 1'b0;
    chk("abort_bank_ready", bank_ready, 2'b00);
    chk("abort_wr_ready", wr_ready, 1);
    write_words(32'h4000, 32);
    chk("abort_fill_done", fill_done, 1);
    chk("abort_final_ready", bank_ready, 2'b10);
    set_port(0, 1, 0, 0);
    set_port(1, 1, 31, 0);
    set_port(2, 0, 5, 0);
    tick();
    chk("abort_b1_r0", {rd_vld[0], dat(0)}, {1'b1, 32'h4000});
    chk("abort_b1_r31", {rd_vld[1], dat(1)}, {1'b1, 32'h401F});
    chk("abort_b0_invalid", {rd_vld[2], dat(2)}, {1'b0, 32'h0});

    // Stall holds outputs
    set_port(0, 1, 2, 0);
    tick();
    chk("pre_stall", {rd_vld[0], dat(0)}, {1'b1, 32'h4002});
    stall = 1'b1;
    set_port(2, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      set_port(0, 1, AW'(7 + k), 0);
      tick();
      chk("stall_hold_p0", {rd_vld[0], dat(0)}, {1'b1, 32'h4002});
      chk("stall_hold_p2", {rd_vld[2], dat(2)}, {1'b0, 32'h0});
    end
    stall = 1'b0;
    set_port(0, 1, 9, 1);
    tick();
    chk("post_stall_p0", {rd_vld[0], dat(0)}, {1'b1, 32'h4016});
    chk("post_stall_p2", {rd_vld[2], dat(2)}, {1'b1, 32'h4001});
    set_port(0, 1, 40, 0);
    tick();
    chk("range_enc", {rd_vld[0], dat(0)}, {1'b0, 32'h0});
    set_port(0, 1, 2, 0);
    tick();
    set_port(0, 1, 40, 1);
    tick();
    chk("range_dec", {rd_vld[0], dat(0)}, {1'b0, 32'h0});

`ifdef ROUND_KEY_PARITY_EN
    start(0);
    write_words(32'h1000, 32);
    chk("par_clean", parity_err, 0);
    dut.mem_q[0][3][0] = ~dut.mem_q[0][3][0];
    set_port(0, 0, 3, 0);
    tick();
    chk("par_err_set", parity_err, 1);
    chk("par_rd_vld", rd_vld[0], 1);
    set_port(0, 0, 4, 0);
    tick(); tick();
    chk("par_err_sticky", parity_err, 1);
    rst_n = 1'b0;
    #1;
    chk("par_err_reset", parity_err, 0);
    rst_n = 1'b1;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
